decode_stage: RTL

Instruction-decode stage that sits directly upstream of the register file in the pipeline. It drives the register-file read addresses from the IF/ID instruction and decodes the instruction into registered ID/EX control. It detects load-use hazards, which stall the front end and insert a bubble, and it bypasses a same-cycle write-back that the register file's read-before-write ordering would otherwise miss.

---
 rtl/decode_stage_if.sv | 56 +++++
 rtl/decode_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Signal bundle between the decode stage and its neighbours: IF/ID, EX feedback,
// write-back, register-file read port and the registered ID/EX controls.
interface decode_stage_if;
  // IF/ID and pipeline control
  logic [31:0] id_instr;
  logic        id_valid;
  logic        flush;
  // feedback from the instruction currently in EX
  logic        ex_mem_rd_in;
  logic [4:0]  ex_wr_reg_in;
  // write-back port
  logic        wb_reg_wr;
  logic [4:0]  wb_wr_reg;
  logic [31:0] wb_data;
  // register-file read port
  logic [31:0] rf_data1;
  logic [31:0] rf_data2;
  logic [4:0]  rd_reg1;
  logic [4:0]  rd_reg2;
  // front-end hold
  logic        stall_if;
  // ID/EX register
  logic        ex_valid;
  logic        ex_reg_wr;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic        ex_alu_src;
  logic        ex_mem_to_reg;
  logic        ex_branch;
  logic        ex_jump;
  logic [2:0]  ex_alu_op;
  logic [4:0]  ex_wr_reg;
  logic [31:0] ex_imm;
  logic [25:0] ex_jtarget;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic        illegal;

  // surrounding pipeline side
  modport master (
    output id_instr, id_valid, flush, ex_mem_rd_in, ex_wr_reg_in,
           wb_reg_wr, wb_wr_reg, wb_data, rf_data1, rf_data2,
    input  rd_reg1, rd_reg2, stall_if, ex_valid, ex_reg_wr, ex_mem_rd,
           ex_mem_wr, ex_alu_src, ex_mem_to_reg, ex_branch, ex_jump,
           ex_alu_op, ex_wr_reg, ex_imm, ex_jtarget, ex_op1, ex_op2, illegal
  );

  // decode stage side
  modport slave (
    input  id_instr, id_valid, flush, ex_mem_rd_in, ex_wr_reg_in,
           wb_reg_wr, wb_wr_reg, wb_data, rf_data1, rf_data2,
    output rd_reg1, rd_reg2, stall_if, ex_valid, ex_reg_wr, ex_mem_rd,
           ex_mem_wr, ex_alu_src, ex_mem_to_reg, ex_branch, ex_jump,
           ex_alu_op, ex_wr_reg, ex_imm, ex_jtarget, ex_op1, ex_op2, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode: register-file addressing, ID/EX control register, load-use
// stall with bubble insertion, and write-back bypass around read-before-write RF.
module decode_stage (
  input  logic         clk,
  input  logic         reset,
  decode_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [4:0] MAX_REG = 5'd16;

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;

  assign w_opcode = bus.id_instr[31:26];
  assign w_funct  = bus.id_instr[5:0];
  assign w_rs     = bus.id_instr[25:21];
  assign w_rt     = bus.id_instr[20:16];
  assign w_rd     = bus.id_instr[15:11];

  assign bus.rd_reg1 = w_rs;
  assign bus.rd_reg2 = w_rt;

  // ---------------------------------------------------------------- decode
  logic       w_known;
  logic       w_writes;
  logic       w_use_rs;
  logic       w_use_rt;
  logic [4:0] w_dest;
  logic [2:0] w_alu_op;
  logic       w_mem_rd;
  logic       w_mem_wr;
  logic       w_alu_src;
  logic       w_mem_to_reg;
  logic       w_branch;
  logic       w_jump;

  always_comb begin
    w_known      = 1'b1;
    w_writes     = 1'b0;
    w_use_rs     = 1'b0;
    w_use_rt     = 1'b0;
    w_dest       = 5'd0;
    w_alu_op     = ALU_ADD;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_writes = 1'b1;
        w_dest   = w_rd;
        case (w_funct)
          FN_ADD:  w_alu_op = ALU_ADD;
          FN_SUB:  w_alu_op = ALU_SUB;
          FN_AND:  w_alu_op = ALU_AND;
          FN_OR:   w_alu_op = ALU_OR;
          FN_SLT:  w_alu_op = ALU_SLT;
          default: w_known  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        w_use_rs  = 1'b1;
        w_writes  = 1'b1;
        w_dest    = w_rt;
        w_alu_src = 1'b1;
      end
      OP_LW: begin
        w_use_rs     = 1'b1;
        w_writes     = 1'b1;
        w_dest       = w_rt;
        w_alu_src    = 1'b1;
        w_mem_rd     = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      OP_SW: begin
        w_use_rs  = 1'b1;
        w_use_rt  = 1'b1;
        w_alu_src = 1'b1;
        w_mem_wr  = 1'b1;
      end
      OP_BEQ: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_alu_op = ALU_SUB;
        w_branch = 1'b1;
      end
      OP_J: begin
        w_jump = 1'b1;
      end
      default: w_known = 1'b0;
    endcase
  end

  // Only 17 architectural registers exist; any referenced index above r16 is illegal.
  logic w_legal;
  assign w_legal = w_known
                 && !(w_use_rs && (w_rs > MAX_REG))
                 && !(w_use_rt && (w_rt > MAX_REG))
                 && !(w_writes && (w_dest > MAX_REG));

  // ---------------------------------------------------------------- hazard
  logic r_ex_valid;
  logic w_src_match;
  logic w_hazard;

  assign w_src_match = (w_use_rs && (w_rs == bus.ex_wr_reg_in))
                    || (w_use_rt && (w_rt == bus.ex_wr_reg_in));
  assign w_hazard    = bus.id_valid && r_ex_valid && bus.ex_mem_rd_in
                    && (bus.ex_wr_reg_in != 5'd0) && w_src_match;
  assign bus.stall_if = w_hazard && !bus.flush;

  // ---------------------------------------------------------------- ID/EX next
  logic        w_valid_next;
  logic        w_reg_wr_next;
  logic        w_mem_rd_next;
  logic        w_mem_wr_next;
  logic        w_alu_src_next;
  logic        w_mem_to_reg_next;
  logic        w_branch_next;
  logic        w_jump_next;
  logic [2:0]  w_alu_op_next;
  logic [4:0]  w_wr_reg_next;
  logic [31:0] w_imm_next;
  logic [25:0] w_jtarget_next;
  logic        w_illegal_next;

  always_comb begin
    w_valid_next      = 1'b0;
    w_reg_wr_next     = 1'b0;
    w_mem_rd_next     = 1'b0;
    w_mem_wr_next     = 1'b0;
    w_alu_src_next    = 1'b0;
    w_mem_to_reg_next = 1'b0;
    w_branch_next     = 1'b0;
    w_jump_next       = 1'b0;
    w_alu_op_next     = 3'd0;
    w_wr_reg_next     = 5'd0;
    w_imm_next        = 32'd0;
    w_jtarget_next    = 26'd0;
    w_illegal_next    = 1'b0;
    // flush outranks the hazard; both, and an empty slot, leave a plain bubble
    if (!bus.flush && bus.id_valid && !w_hazard) begin
      if (!w_legal) begin
        w_illegal_next = 1'b1;
      end else begin
        w_valid_next      = 1'b1;
        w_reg_wr_next     = w_writes && (w_dest != 5'd0);
        w_mem_rd_next     = w_mem_rd;
        w_mem_wr_next     = w_mem_wr;
        w_alu_src_next    = w_alu_src;
        w_mem_to_reg_next = w_mem_to_reg;
        w_branch_next     = w_branch;
        w_jump_next       = w_jump;
        w_alu_op_next     = w_alu_op;
        w_wr_reg_next     = w_dest;
        w_imm_next        = {{16{bus.id_instr[15]}}, bus.id_instr[15:0]};
        w_jtarget_next    = bus.id_instr[25:0];
      end
    end
  end

  logic        r_reg_wr;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic        r_alu_src;
  logic        r_mem_to_reg;
  logic        r_branch;
  logic        r_jump;
  logic [2:0]  r_alu_op;
  logic [4:0]  r_wr_reg;
  logic [31:0] r_imm;
  logic [25:0] r_jtarget;
  logic        r_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid   <= 1'b0;
      r_reg_wr     <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_alu_op     <= 3'd0;
      r_wr_reg     <= 5'd0;
      r_imm        <= 32'd0;
      r_jtarget    <= 26'd0;
      r_illegal    <= 1'b0;
    end else begin
      r_ex_valid   <= w_valid_next;
      r_reg_wr     <= w_reg_wr_next;
      r_mem_rd     <= w_mem_rd_next;
      r_mem_wr     <= w_mem_wr_next;
      r_alu_src    <= w_alu_src_next;
      r_mem_to_reg <= w_mem_to_reg_next;
      r_branch     <= w_branch_next;
      r_jump       <= w_jump_next;
      r_alu_op     <= w_alu_op_next;
      r_wr_reg     <= w_wr_reg_next;
      r_imm        <= w_imm_next;
      r_jtarget    <= w_jtarget_next;
      r_illegal    <= w_illegal_next;
    end
  end

  assign bus.ex_valid      = r_ex_valid;
  assign bus.ex_reg_wr     = r_reg_wr;
  assign bus.ex_mem_rd     = r_mem_rd;
  assign bus.ex_mem_wr     = r_mem_wr;
  assign bus.ex_alu_src    = r_alu_src;
  assign bus.ex_mem_to_reg = r_mem_to_reg;
  assign bus.ex_branch     = r_branch;
  assign bus.ex_jump       = r_jump;
  assign bus.ex_alu_op     = r_alu_op;
  assign bus.ex_wr_reg     = r_wr_reg;
  assign bus.ex_imm        = r_imm;
  assign bus.ex_jtarget    = r_jtarget;
  assign bus.illegal       = r_illegal;

  // ---------------------------------------------------------------- bypass
  // The RF returns pre-write data when read and written on the same edge, so a
  // matching write-back is remembered and substituted when the data arrives.
  logic [31:0] r_wb_data;
  logic [4:0]  w_src_addr [2];
  logic [31:0] w_rf_data  [2];
  logic [31:0] w_op       [2];

  assign w_src_addr[0] = w_rs;
  assign w_src_addr[1] = w_rt;
  assign w_rf_data[0]  = bus.rf_data1;
  assign w_rf_data[1]  = bus.rf_data2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_data <= 32'd0;
    end else begin
      r_wb_data <= bus.wb_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_byp
      logic r_byp;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_byp <= 1'b0;
        end else begin
          r_byp <= bus.wb_reg_wr && (bus.wb_wr_reg != 5'd0)
                && (bus.wb_wr_reg == w_src_addr[gi]);
        end
      end
      assign w_op[gi] = r_byp ? r_wb_data : w_rf_data[gi];
    end
  endgenerate

  assign bus.ex_op1 = w_op[0];
  assign bus.ex_op2 = w_op[1];

endmodule
